// File: rtl/noc_injection_arbiter.sv
// noc_injection_arbiter: shares one router injection port between NUM_SOURCES
// requesters. Round-robin, packet-granular (wormhole) arbitration, gated by a
// credit counter that mirrors the router input buffer.
// Optional build macro NOC_INJ_ARB_STATS_EN adds the stall_cycles counter port.
module noc_injection_arbiter #(
    parameter int unsigned NUM_SOURCES       = 4,
    parameter int unsigned DEST_WIDTH        = 4,
    parameter int unsigned FLIT_WIDTH        = 256,
    parameter int unsigned FLIT_BUFFER_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_WIDTH-1:0]  src_data    [NUM_SOURCES],
    input  logic [DEST_WIDTH-1:0]  src_dest    [NUM_SOURCES],
    input  logic [NUM_SOURCES-1:0] src_is_tail,
    input  logic [NUM_SOURCES-1:0] src_valid,
    output logic [NUM_SOURCES-1:0] src_ready,
    output logic [FLIT_WIDTH-1:0]  data_out,
    output logic [DEST_WIDTH-1:0]  dest_out,
    output logic                   is_tail_out,
    output logic                   send_out,
    input  logic                   credit_in,
    output logic                   credit_overflow
`ifdef NOC_INJ_ARB_STATS_EN
    ,
    output logic [31:0]            stall_cycles
`endif
);

    localparam int unsigned IDX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int unsigned CNT_W = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FLIT_BUFFER_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SOURCES - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Increment a source index modulo NUM_SOURCES.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    endfunction

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       lock_id_q, lock_id_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       credit_cnt_q, credit_cnt_d;
    logic                   credit_overflow_q, credit_overflow_d;
    logic                   send_q, send_d;
    logic [FLIT_WIDTH-1:0]  data_q, data_d;
    logic [DEST_WIDTH-1:0]  dest_q, dest_d;
    logic                   is_tail_q, is_tail_d;

    logic [IDX_W-1:0]       grantee;
    logic                   found;
    logic                   accept;
    logic                   has_credit;

    // Grantee: locked source while a packet is open, else first valid from rr_ptr.
    always_comb begin
        logic [IDX_W-1:0] idx;
        grantee = rr_ptr_q;
        found   = 1'b0;
        idx     = rr_ptr_q;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            if (!found && src_valid[idx]) begin
                grantee = idx;
                found   = 1'b1;
            end
            idx = wrap_inc(idx);
        end
        if (state_q == ST_LOCKED) begin
            grantee = lock_id_q;
        end
    end

    // Ready to the grantee only, and only while a buffer slot is free.
    always_comb begin
        src_ready  = '0;
        has_credit = (credit_cnt_q != '0);
        if (!rst && has_credit && ((state_q == ST_LOCKED) || found)) begin
            src_ready[grantee] = 1'b1;
        end
        accept = src_valid[grantee] & src_ready[grantee];
    end

    // Next-state: lock/unlock, round-robin pointer, output capture and credits.
    always_comb begin
        state_d           = state_q;
        lock_id_d         = lock_id_q;
        rr_ptr_d          = rr_ptr_q;
        credit_cnt_d      = credit_cnt_q;
        credit_overflow_d = credit_overflow_q;
        send_d            = 1'b0;
        data_d            = data_q;
        dest_d            = dest_q;
        is_tail_d         = is_tail_q;

        if (accept) begin
            send_d    = 1'b1;
            data_d    = src_data[grantee];
            dest_d    = src_dest[grantee];
            is_tail_d = src_is_tail[grantee];
            if (src_is_tail[grantee]) begin
                state_d  = ST_IDLE;
                rr_ptr_d = wrap_inc(grantee);
            end else begin
                state_d   = ST_LOCKED;
                lock_id_d = grantee;
            end
        end

        // A send and a returned credit in the same cycle cancel out.
        if (accept && !credit_in) begin
            credit_cnt_d = credit_cnt_q - CNT_W'(1);
        end else if (credit_in && !accept) begin
            if (credit_cnt_q == CNT_MAX) begin
                credit_overflow_d = 1'b1;
            end else begin
                credit_cnt_d = credit_cnt_q + CNT_W'(1);
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            lock_id_q         <= '0;
            rr_ptr_q          <= '0;
            credit_cnt_q      <= CNT_MAX;
            credit_overflow_q <= 1'b0;
            send_q            <= 1'b0;
            data_q            <= '0;
            dest_q            <= '0;
            is_tail_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            lock_id_q         <= lock_id_d;
            rr_ptr_q          <= rr_ptr_d;
            credit_cnt_q      <= credit_cnt_d;
            credit_overflow_q <= credit_overflow_d;
            send_q            <= send_d;
            data_q            <= data_d;
            dest_q            <= dest_d;
            is_tail_q         <= is_tail_d;
        end
    end

    assign send_out        = send_q;
    assign data_out        = data_q;
    assign dest_out        = dest_q;
    assign is_tail_out     = is_tail_q;
    assign credit_overflow = credit_overflow_q;

`ifdef NOC_INJ_ARB_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Count cycles with pending requests but no flit accepted; wraps naturally.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((|src_valid) && !accept) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_noc_injection_arbiter.sv
// Testbench for noc_injection_arbiter: directed scenarios plus randomized
// traffic, checked against a behavioural model of the arbitration rules.
module tb_noc_injection_arbiter;

    localparam int NS    = 4;
    localparam int DEPTH = 2;

    logic           clk;
    logic           rst;
    logic [255:0]   src_data [NS];
    logic [3:0]     src_dest [NS];
    logic [NS-1:0]  src_is_tail;
    logic [NS-1:0]  src_valid;
    logic [NS-1:0]  src_ready;
    logic [255:0]   data_out;
    logic [3:0]     dest_out;
    logic           is_tail_out;
    logic           send_out;
    logic           credit_in;
    logic           credit_overflow;
`ifdef NOC_INJ_ARB_STATS_EN
    logic [31:0]    stall_cycles;
`endif

    noc_injection_arbiter #(
        .NUM_SOURCES      (NS),
        .DEST_WIDTH       (4),
        .FLIT_WIDTH       (256),
        .FLIT_BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .src_data       (src_data),
        .src_dest       (src_dest),
        .src_is_tail    (src_is_tail),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .data_out       (data_out),
        .dest_out       (dest_out),
        .is_tail_out    (is_tail_out),
        .send_out       (send_out),
        .credit_in      (credit_in),
        .credit_overflow(credit_overflow)
`ifdef NOC_INJ_ARB_STATS_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    int            m_cred;
    bit            m_locked;
    int            m_owner;
    int            m_rr;
    logic          m_ovf, m_send, m_tail;
    logic [255:0]  m_data;
    logic [3:0]    m_dest;
    logic [31:0]   m_stall;
    logic [NS-1:0] exp_ready, act_ready;
    int            acc_src;

    // Whom the arbiter should serve this cycle (-1: nobody).
    function automatic int m_grantee();
        if (m_locked) return m_owner;
        for (int k = 0; k < NS; k++) begin
            int i;
            i = (m_rr + k) % NS;
            if (src_valid[i]) return i;
        end
        return -1;
    endfunction

    // Advance one clock: predict ready/accept, update model, sample after edge.
    task automatic cyc();
        int g;
        #1;
        g = m_grantee();
        exp_ready = '0;
        if (!rst && g >= 0 && m_cred > 0 && (m_locked || src_valid[g])) exp_ready[g] = 1'b1;
        act_ready = src_ready;
        acc_src = -1;
        if (g >= 0) if (exp_ready[g] && src_valid[g]) acc_src = g;
        if (rst) begin
            m_cred = DEPTH; m_locked = 0; m_owner = 0; m_rr = 0;
            m_ovf = 0; m_send = 0; m_tail = 0; m_data = '0; m_dest = '0; m_stall = '0;
        end else begin
            if (acc_src >= 0) begin
                m_send = 1; m_data = src_data[g]; m_dest = src_dest[g]; m_tail = src_is_tail[g];
                if (src_is_tail[g]) begin m_locked = 0; m_rr = (g + 1) % NS; end
                else begin m_locked = 1; m_owner = g; end
            end else begin
                m_send = 0;
            end
            if (acc_src >= 0 && !credit_in) m_cred = m_cred - 1;
            else if (acc_src < 0 && credit_in) begin
                if (m_cred == DEPTH) m_ovf = 1;
                else m_cred = m_cred + 1;
            end
            if (src_valid != '0 && acc_src < 0) m_stall = m_stall + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        src_valid = '0; src_is_tail = '0; credit_in = 1'b0;
        for (int s = 0; s < NS; s++) begin
            src_data[s] = '0; src_dest[s] = '0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        src_valid = 4'b1011; src_is_tail = 4'b0101; credit_in = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cyc();
            n_cmp++;
            if (act_ready !== 4'b0000) begin
                n_err++; $display("FAIL reset_ready: got %b want 0000", act_ready);
            end
            n_cmp++;
            if ({send_out, is_tail_out, dest_out, credit_overflow} !== 7'b0 || data_out !== 256'b0) begin
                n_err++; $display("FAIL reset_outputs: got send=%b tail=%b dest=%h ovf=%b data=%h want all zero",
                                  send_out, is_tail_out, dest_out, credit_overflow, data_out);
            end
`ifdef NOC_INJ_ARB_STATS_EN
            n_cmp++;
            if (stall_cycles !== 32'd0) begin
                n_err++; $display("FAIL reset_stall: got %0d want 0", stall_cycles);
            end
`endif
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single_flit();
        do_reset();
        src_valid = 4'b0001; src_is_tail = 4'b0001; src_dest[0] = 4'd3; src_data[0] = 256'hA5;
        cyc();
        n_cmp++;
        if (act_ready !== 4'b0001) begin
            n_err++; $display("FAIL single_ready: got %b want 0001", act_ready);
        end
        n_cmp++;
        if ({send_out, is_tail_out, dest_out} !== {1'b1, 1'b1, 4'd3} || data_out !== 256'hA5) begin
            n_err++; $display("FAIL single_out: got send=%b tail=%b dest=%0d data=%h want 1 1 3 a5",
                              send_out, is_tail_out, dest_out, data_out);
        end
        // rr_ptr now 1: with sources 0 and 1 both requesting, source 1 wins.
        src_valid = 4'b0011; src_is_tail = 4'b0011; src_data[1] = 256'h5A; src_dest[1] = 4'd7;
        credit_in = 1'b1;
        cyc();
        n_cmp++;
        if (act_ready !== 4'b0010 || act_ready !== exp_ready) begin
            n_err++; $display("FAIL single_rr: got %b want 0010 (model %b)", act_ready, exp_ready);
        end
        n_cmp++;
        if (send_out !== 1'b1 || data_out !== 256'h5A || dest_out !== 4'd7) begin
            n_err++; $display("FAIL single_second: got send=%b dest=%0d data=%h want 1 7 5a",
                              send_out, dest_out, data_out);
        end
        clear_inputs();
        cyc();
    endtask

    task automatic test_wormhole();
        int ps [NS];
        int sent [$];
        int first_cyc, last_cyc;
        do_reset();
        for (int s = 0; s < NS; s++) ps[s] = 0;
        first_cyc = -1; last_cyc = -1;
        for (int c = 0; c < 12; c++) begin
            for (int s = 0; s < NS; s += 2) begin
                src_valid[s]   = (ps[s] < 3);
                src_is_tail[s] = (ps[s] == 2);
                src_dest[s]    = 4'(s);
                src_data[s]    = 256'(s * 16 + ps[s]);
            end
            credit_in = send_out;
            if (ps[0] < 3) begin
                #1;
                n_cmp++;
                if (src_ready[2] !== 1'b0) begin
                    n_err++; $display("FAIL wormhole_starve cyc %0d: src_ready[2]=%b want 0", c, src_ready[2]);
                end
            end
            cyc();
            if (acc_src >= 0) ps[acc_src]++;
            n_cmp++;
            if ({act_ready, send_out, is_tail_out, dest_out, credit_overflow} !==
                {exp_ready, m_send, m_tail, m_dest, m_ovf} || data_out !== m_data) begin
                n_err++; $display("FAIL wormhole_model cyc %0d: got rdy=%b send=%b tail=%b dest=%h ovf=%b data=%h want %b %b %b %h %b %h",
                    c, act_ready, send_out, is_tail_out, dest_out, credit_overflow, data_out[7:0],
                    exp_ready, m_send, m_tail, m_dest, m_ovf, m_data[7:0]);
            end
            if (send_out === 1'b1) begin
                sent.push_back(int'(data_out[7:0]));
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
            end
        end
        n_cmp++;
        if (sent.size() != 6 || last_cyc - first_cyc != 5) begin
            n_err++; $display("FAIL wormhole_contig: got %0d sends over %0d cycles want 6 over 6",
                              sent.size(), last_cyc - first_cyc + 1);
        end else begin
            int exp_seq [6];
            exp_seq = '{8'h00, 8'h01, 8'h02, 8'h20, 8'h21, 8'h22};
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (sent[i] != exp_seq[i]) begin
                    n_err++; $display("FAIL wormhole_order[%0d]: got %h want %h", i, sent[i], exp_seq[i]);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_credit_stall();
        int ps;
        int nsend;
        do_reset();
        ps = 0; nsend = 0;
        for (int c = 0; c < 6; c++) begin
            src_valid[1] = (ps < 4); src_is_tail[1] = (ps == 3); src_data[1] = 256'(16 + ps);
            cyc();
            if (acc_src >= 0) ps++;
            if (send_out === 1'b1) nsend++;
            n_cmp++;
            if ({act_ready, send_out, credit_overflow} !== {exp_ready, m_send, m_ovf} || data_out !== m_data) begin
                n_err++; $display("FAIL stall_model cyc %0d: got rdy=%b send=%b data=%h want %b %b %h",
                                  c, act_ready, send_out, data_out[7:0], exp_ready, m_send, m_data[7:0]);
            end
        end
        n_cmp++;
        if (nsend != 2 || act_ready[1] !== 1'b0) begin
            n_err++; $display("FAIL stall_limit: got %0d sends ready=%b want 2 sends ready=0", nsend, act_ready[1]);
        end
        // Credit at cycle t must not let a flit through in cycle t.
        credit_in = 1'b1; src_data[1] = 256'(16 + ps);
        cyc();
        n_cmp++;
        if (act_ready[1] !== 1'b0) begin
            n_err++; $display("FAIL stall_nobypass: got ready=%b want 0", act_ready[1]);
        end
        credit_in = 1'b0;
        cyc();
        if (acc_src >= 0) ps++;
        n_cmp++;
        if (act_ready[1] !== 1'b1) begin
            n_err++; $display("FAIL stall_resume: got ready=%b want 1", act_ready[1]);
        end
        n_cmp++;
        if (send_out !== 1'b1 || data_out !== 256'h12) begin
            n_err++; $display("FAIL stall_third: got send=%b data=%h want 1 12", send_out, data_out[7:0]);
        end
        for (int c = 0; c < 6; c++) begin
            src_valid[1] = (ps < 4); src_is_tail[1] = (ps == 3); src_data[1] = 256'(16 + ps);
            credit_in = (c % 2 == 0);
            cyc();
            if (acc_src >= 0) ps++;
            n_cmp++;
            if ({act_ready, send_out, is_tail_out, credit_overflow} !== {exp_ready, m_send, m_tail, m_ovf}) begin
                n_err++; $display("FAIL stall_drain cyc %0d: got rdy=%b send=%b tail=%b ovf=%b want %b %b %b %b",
                    c, act_ready, send_out, is_tail_out, credit_overflow, exp_ready, m_send, m_tail, m_ovf);
            end
        end
        clear_inputs();
    endtask

    task automatic test_round_robin();
        int order [$];
        do_reset();
        src_valid = 4'b1111; src_is_tail = 4'b1111;
        for (int s = 0; s < NS; s++) src_data[s] = 256'(s);
        for (int c = 0; c < 9; c++) begin
            credit_in = send_out;
            cyc();
            if (send_out === 1'b1) order.push_back(int'(data_out[7:0]));
        end
        n_cmp++;
        if (order.size() < 8) begin
            n_err++; $display("FAIL rr_count: got %0d grants want >= 8", order.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (order[i] != i % NS) begin
                    n_err++; $display("FAIL rr_order[%0d]: got source %0d want %0d", i, order[i], i % NS);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_credit_overflow();
        logic [NS-1:0] rdy_seq [4];
        do_reset();
        src_is_tail = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            src_valid = 4'b0001;
            credit_in = (c == 1);
            cyc();
            rdy_seq[c] = act_ready;
        end
        n_cmp++;
        if ({rdy_seq[0][0], rdy_seq[1][0], rdy_seq[2][0], rdy_seq[3][0]} !== 4'b1110) begin
            n_err++; $display("FAIL ovf_samecycle: got ready seq %b%b%b%b want 1110",
                              rdy_seq[0][0], rdy_seq[1][0], rdy_seq[2][0], rdy_seq[3][0]);
        end
        src_valid = '0;
        credit_in = 1'b1;
        cyc(); cyc();
        n_cmp++;
        if (credit_overflow !== 1'b0) begin
            n_err++; $display("FAIL ovf_early: got %b want 0", credit_overflow);
        end
        cyc();
        credit_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (credit_overflow !== 1'b1 || m_ovf !== 1'b1) begin
                n_err++; $display("FAIL ovf_sticky %0d: got %b want 1", c, credit_overflow);
            end
            cyc();
        end
        do_reset();
        n_cmp++;
        if (credit_overflow !== 1'b0) begin
            n_err++; $display("FAIL ovf_clear: got %b want 0", credit_overflow);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        src_valid = 4'b1000; src_is_tail = 4'b0000; src_data[3] = 256'h33;
        for (int c = 0; c < 2; c++) begin
            credit_in = send_out;
            cyc();
        end
        rst = 1'b1;
        src_valid = 4'b1001; src_data[0] = 256'h0C; src_is_tail = 4'b0001; credit_in = 1'b0;
        cyc();
        rst = 1'b0;
        n_cmp++;
        if (act_ready !== 4'b0000 || send_out !== 1'b0) begin
            n_err++; $display("FAIL midrst_out: got ready=%b send=%b want 0000 0", act_ready, send_out);
        end
`ifdef NOC_INJ_ARB_STATS_EN
        n_cmp++;
        if (stall_cycles !== 32'd0) begin
            n_err++; $display("FAIL midrst_stall: got %0d want 0", stall_cycles);
        end
`endif
        src_valid = 4'b0001;
        cyc();
        n_cmp++;
        if (act_ready !== 4'b0001) begin
            n_err++; $display("FAIL midrst_grant: got %b want 0001", act_ready);
        end
        n_cmp++;
        if (send_out !== 1'b1 || data_out !== 256'h0C) begin
            n_err++; $display("FAIL midrst_send: got send=%b data=%h want 1 0c", send_out, data_out[7:0]);
        end
        // Counter is back at full depth: one more flit fits, then none.
        for (int c = 0; c < 2; c++) begin
            cyc();
            n_cmp++;
            if (act_ready !== exp_ready || act_ready[0] !== (c == 0)) begin
                n_err++; $display("FAIL midrst_credit %0d: got %b want %b", c, act_ready, exp_ready);
            end
        end
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < NS; s++) begin
                src_valid[s]   = ($urandom_range(0, 9) < 6);
                src_is_tail[s] = ($urandom_range(0, 2) == 0);
                src_dest[s]    = 4'($urandom);
                src_data[s]    = {$urandom, $urandom, $urandom, $urandom,
                                  $urandom, $urandom, $urandom, $urandom};
            end
            credit_in = ($urandom_range(0, 1) == 1);
            cyc();
            n_cmp++;
            if ({act_ready, send_out, is_tail_out, dest_out, credit_overflow} !==
                {exp_ready, m_send, m_tail, m_dest, m_ovf}) begin
                n_err++; $display("FAIL random_ctrl cyc %0d: got rdy=%b send=%b tail=%b dest=%h ovf=%b want %b %b %b %h %b",
                    c, act_ready, send_out, is_tail_out, dest_out, credit_overflow,
                    exp_ready, m_send, m_tail, m_dest, m_ovf);
            end
            n_cmp++;
            if (data_out !== m_data) begin
                n_err++; $display("FAIL random_data cyc %0d: got %h want %h", c, data_out, m_data);
            end
`ifdef NOC_INJ_ARB_STATS_EN
            n_cmp++;
            if (stall_cycles !== m_stall) begin
                n_err++; $display("FAIL random_stall cyc %0d: got %0d want %0d", c, stall_cycles, m_stall);
            end
`endif
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        m_cred = DEPTH; m_locked = 0; m_owner = 0; m_rr = 0;
        m_ovf = 0; m_send = 0; m_tail = 0; m_data = '0; m_dest = '0; m_stall = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_flit();
        test_wormhole();
        test_credit_stall();
        test_round_robin();
        test_credit_overflow();
        test_reset_mid_packet();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
